alu_cmd_issuer: RTL

- Upstream stage of the 4-bit ALU: buffers operation commands {a, b, select} in a small FIFO.
- Issues one command at a time to the ALU's combinational inputs, then registers the ALU result and carry.
- Presents each registered result on a valid/ready output handshake, so producers and consumers of ALU work decouple from the combinational ALU.

---
 rtl/alu_cmd_issuer.sv | 82 ++++++++
 1 files changed

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: command FIFO feeding a combinational 4-bit ALU, registered result on valid/ready.
// Optional res_zero output enabled by defining ALU_CMD_ZERO_FLAG_EN.
module alu_cmd_issuer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [1:0]       cmd_sel,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [1:0]       alu_sel,
    input  logic [3:0]       alu_result,
    input  logic             alu_carry,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_data,
    output logic             res_carry,
`ifdef ALU_CMD_ZERO_FLAG_EN
    output logic             res_zero,
`endif
    output logic [PTR_W:0]   fifo_count
);
    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);
    state_t           state;
    logic [9:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             has, push, pop;
    assign cmd_ready = fifo_count != FULL;
    assign has       = fifo_count != '0;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = has && (state == IDLE || (state == HOLD && res_ready));
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {cmd_a, cmd_b, cmd_sel};
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_carry  <= 1'b0;
`ifdef ALU_CMD_ZERO_FLAG_EN
            res_zero   <= 1'b0;
`endif
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr                  <= rd_ptr + 1'b1;
                {alu_a, alu_b, alu_sel} <= mem[rd_ptr];
            end
            fifo_count <= (push && !pop) ? fifo_count + 1'b1 :
                          (pop && !push) ? fifo_count - 1'b1 : fifo_count;
            case (state)
                IDLE: if (pop) state <= ISSUE;
                ISSUE: begin
                    res_data  <= alu_result;
                    res_carry <= alu_carry;
`ifdef ALU_CMD_ZERO_FLAG_EN
                    res_zero  <= alu_result == 4'h0;
`endif
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: if (res_ready) begin
                    res_valid <= 1'b0;
                    state     <= has ? ISSUE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
